// File: rtl/pc_sequencer.sv
// Fetch-side next-PC controller: owns the PC, drives the instruction-memory handshake,
// and sequences prioritised redirects (trap > branch > jump) around an in-flight fetch.
module pc_sequencer #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = 'h100
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            hazard_stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_stall,
    output logic            fetch_valid,
    output logic            flush
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN
    } state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pend_target, pend_next;
    logic            outstanding;
    logic            redir;
    logic [XLEN-1:0] redir_raw, redir_target, pc_inc;

    // Redirect target selection, word-aligned.
    always_comb begin
        redir = trap | branch_taken | jump;
        if (trap)              redir_raw = TRAP_VEC;
        else if (branch_taken) redir_raw = branch_target;
        else                   redir_raw = jump_target;
        redir_target = {redir_raw[XLEN-1:2], 2'b00};
        pc_inc       = pc + XLEN'(4);
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next  = state;
        pc_next     = pc;
        pend_next   = pend_target;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        case (state)
            BOOT: state_next = FETCH;
            FETCH: begin
                imem_req = outstanding | ~hazard_stall | redir;
                if (redir) begin
                    // redir forces imem_req, so imem_ready alone marks the beat here.
                    flush = 1'b1;
                    if (imem_ready) begin
                        pc_next = redir_target;
                    end else begin
                        pend_next  = redir_target;
                        state_next = DRAIN;
                    end
                end else if (imem_req && imem_ready) begin
                    fetch_valid = 1'b1;
                    pc_next     = pc_inc;
                end
            end
            DRAIN: begin
                // The stale request at the old pc must complete before the redirect takes over.
                imem_req = 1'b1;
                if (redir) begin
                    flush     = 1'b1;
                    pend_next = redir_target;
                end
                if (imem_ready) begin
                    pc_next    = redir ? redir_target : pend_target;
                    state_next = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    assign imem_addr = pc;
    assign pc_stall  = (pc_next == pc);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            pend_target <= '0;
            outstanding <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            pend_target <= pend_next;
            outstanding <= imem_req & ~imem_ready;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a scoreboard of expected fetch addresses plus
// per-scenario inline checks of handshake, redirect and reset behaviour.
module tb_pc_sequencer;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            hazard_stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            trap;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            pc_stall;
    logic            fetch_valid;
    logic            flush;

    logic [XLEN-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    pc_sequencer #(.XLEN(64), .RESET_PC(64'h0), .TRAP_VEC(64'h100)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .hazard_stall(hazard_stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .trap(trap),
        .pc(pc), .pc_next(pc_next), .pc_stall(pc_stall),
        .fetch_valid(fetch_valid), .flush(flush)
    );

    always #5 clk = ~clk;

    // Move to the sampling point and retire any reported fetch against the scoreboard.
    task automatic at_sample();
        logic [XLEN-1:0] exp;
        @(negedge clk);
        if (fetch_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_fetch addr=%h required=no fetch", imem_addr);
            end else begin
                exp = exp_q.pop_front();
                if (imem_addr !== exp) begin
                    errors++;
                    $display("FAIL sb_fetch_addr got=%h required=%h", imem_addr, exp);
                end
            end
        end
    endtask

    task automatic at_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hazard_stall  = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        trap          = 1'b0;
        imem_ready    = 1'b1;
    endtask

    // Reset for three cycles, then pass the single BOOT cycle.
    task automatic do_reset();
        exp_q.delete();
        clear_inputs();
        rst = 1'b1;
        repeat (3) at_drive();
        rst = 1'b0;
        at_sample();
        at_drive();
    endtask

    task automatic run_beats(input int n, input logic [XLEN-1:0] base);
        for (int i = 0; i < n; i++) exp_q.push_back(base + XLEN'(4 * i));
        for (int i = 0; i < n; i++) begin
            at_sample();
            at_drive();
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_fetches got=%0d pending required=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        exp_q.delete();
        clear_inputs();
        rst = 1'b1;
        repeat (3) begin
            at_sample();
            checks++;
            if (pc !== 64'h0 || imem_req !== 1'b0 || pc_stall !== 1'b1 ||
                fetch_valid !== 1'b0 || flush !== 1'b0) begin
                errors++;
                $display("FAIL reset_state got pc=%h req=%b stall=%b fv=%b flush=%b required pc=0 req=0 stall=1 fv=0 flush=0",
                         pc, imem_req, pc_stall, fetch_valid, flush);
            end
            at_drive();
        end
        rst = 1'b0;
        at_sample();
        checks++;
        if (imem_req !== 1'b0 || pc_stall !== 1'b1) begin
            errors++;
            $display("FAIL boot_cycle got req=%b stall=%b required req=0 stall=1", imem_req, pc_stall);
        end
        at_drive();
        run_beats(4, 64'h0);
        check_drained("reset");
    endtask

    task automatic test_wait();
        do_reset();
        run_beats(2, 64'h0);
        imem_ready = 1'b0;
        repeat (3) begin
            at_sample();
            checks++;
            if (imem_addr !== 64'h8 || fetch_valid !== 1'b0 || pc_stall !== 1'b1 || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL wait_hold got addr=%h fv=%b stall=%b req=%b required addr=8 fv=0 stall=1 req=1",
                         imem_addr, fetch_valid, pc_stall, imem_req);
            end
            at_drive();
        end
        imem_ready = 1'b1;
        run_beats(2, 64'h8);
        check_drained("wait");
    endtask

    task automatic test_branch();
        do_reset();
        run_beats(4, 64'h0);
        branch_taken  = 1'b1;
        branch_target = 64'h200;
        at_sample();
        checks++;
        if (fetch_valid !== 1'b0 || flush !== 1'b1 || pc_next !== 64'h200 || imem_addr !== 64'h10) begin
            errors++;
            $display("FAIL branch_beat got fv=%b flush=%b pc_next=%h addr=%h required fv=0 flush=1 pc_next=200 addr=10",
                     fetch_valid, flush, pc_next, imem_addr);
        end
        at_drive();
        branch_taken = 1'b0;
        run_beats(1, 64'h200);
        check_drained("branch");
    endtask

    task automatic test_jump_wait();
        do_reset();
        run_beats(8, 64'h0);
        imem_ready = 1'b0;
        at_sample();
        at_drive();
        jump        = 1'b1;
        jump_target = 64'h83;
        at_sample();
        checks++;
        if (flush !== 1'b1 || fetch_valid !== 1'b0 || pc_next !== 64'h20 || imem_addr !== 64'h20) begin
            errors++;
            $display("FAIL jump_wait_entry got flush=%b fv=%b pc_next=%h addr=%h required flush=1 fv=0 pc_next=20 addr=20",
                     flush, fetch_valid, pc_next, imem_addr);
        end
        at_drive();
        jump = 1'b0;
        at_sample();
        checks++;
        if (imem_addr !== 64'h20 || imem_req !== 1'b1 || fetch_valid !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL jump_drain_hold got addr=%h req=%b fv=%b flush=%b required addr=20 req=1 fv=0 flush=0",
                     imem_addr, imem_req, fetch_valid, flush);
        end
        at_drive();
        imem_ready = 1'b1;
        at_sample();
        checks++;
        if (fetch_valid !== 1'b0 || pc_next !== 64'h80 || imem_addr !== 64'h20) begin
            errors++;
            $display("FAIL jump_stale_beat got fv=%b pc_next=%h addr=%h required fv=0 pc_next=80 addr=20",
                     fetch_valid, pc_next, imem_addr);
        end
        at_drive();
        run_beats(1, 64'h80);
        check_drained("jump_wait");
    endtask

    task automatic test_priority();
        do_reset();
        trap = 1'b1; branch_taken = 1'b1; branch_target = 64'h300; jump = 1'b1; jump_target = 64'h400;
        at_sample();
        checks++;
        if (pc_next !== 64'h100 || flush !== 1'b1) begin
            errors++;
            $display("FAIL prio_trap got pc_next=%h flush=%b required pc_next=100 flush=1", pc_next, flush);
        end
        at_drive();
        trap = 1'b0;
        at_sample();
        checks++;
        if (pc_next !== 64'h300) begin
            errors++;
            $display("FAIL prio_branch got pc_next=%h required 300", pc_next);
        end
        at_drive();
        branch_taken = 1'b0;
        at_sample();
        checks++;
        if (pc_next !== 64'h400) begin
            errors++;
            $display("FAIL prio_jump got pc_next=%h required 400", pc_next);
        end
        at_drive();
        jump = 1'b0;
        run_beats(1, 64'h400);
        check_drained("priority");
    endtask

    task automatic test_back_to_back();
        do_reset();
        imem_ready = 1'b0;
        at_sample();
        at_drive();
        branch_taken = 1'b1; branch_target = 64'h200;
        at_sample();
        at_drive();
        branch_taken = 1'b0;
        jump = 1'b1; jump_target = 64'h300;
        at_sample();
        checks++;
        if (flush !== 1'b1 || pc_next !== 64'h0) begin
            errors++;
            $display("FAIL drain_redir got flush=%b pc_next=%h required flush=1 pc_next=0", flush, pc_next);
        end
        at_drive();
        jump = 1'b0;
        imem_ready = 1'b1;
        at_sample();
        checks++;
        if (pc_next !== 64'h300 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_overwrite got pc_next=%h fv=%b required pc_next=300 fv=0", pc_next, fetch_valid);
        end
        at_drive();
        run_beats(1, 64'h300);
        imem_ready = 1'b0;
        at_sample();
        at_drive();
        branch_taken = 1'b1; branch_target = 64'h500;
        at_sample();
        at_drive();
        branch_taken = 1'b0;
        imem_ready = 1'b1;
        trap = 1'b1;
        at_sample();
        checks++;
        if (pc_next !== 64'h100 || flush !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_same_cycle got pc_next=%h flush=%b fv=%b required pc_next=100 flush=1 fv=0",
                     pc_next, flush, fetch_valid);
        end
        at_drive();
        trap = 1'b0;
        run_beats(1, 64'h100);
        check_drained("back_to_back");
    endtask

    task automatic test_wrap();
        do_reset();
        jump = 1'b1; jump_target = 64'hFFFF_FFFF_FFFF_FFFE;
        at_sample();
        at_drive();
        jump = 1'b0;
        run_beats(2, 64'hFFFF_FFFF_FFFF_FFFC);
        check_drained("wrap");
    endtask

    task automatic test_hazard();
        do_reset();
        hazard_stall = 1'b1;
        repeat (2) begin
            at_sample();
            checks++;
            if (imem_req !== 1'b0 || pc_stall !== 1'b1 || fetch_valid !== 1'b0 || pc !== 64'h0) begin
                errors++;
                $display("FAIL hazard_idle got req=%b stall=%b fv=%b pc=%h required req=0 stall=1 fv=0 pc=0",
                         imem_req, pc_stall, fetch_valid, pc);
            end
            at_drive();
        end
        hazard_stall = 1'b0;
        imem_ready   = 1'b0;
        at_sample();
        at_drive();
        hazard_stall = 1'b1;
        at_sample();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            errors++;
            $display("FAIL hazard_outstanding got req=%b addr=%h required req=1 addr=0", imem_req, imem_addr);
        end
        at_drive();
        imem_ready = 1'b1;
        run_beats(1, 64'h0);
        at_sample();
        checks++;
        if (imem_req !== 1'b0 || pc !== 64'h4) begin
            errors++;
            $display("FAIL hazard_after_beat got req=%b pc=%h required req=0 pc=4", imem_req, pc);
        end
        at_drive();
        check_drained("hazard");
        hazard_stall = 1'b0;
        imem_ready   = 1'b0;
        at_sample();
        at_drive();
        branch_taken = 1'b1; branch_target = 64'h200;
        at_sample();
        at_drive();
        branch_taken = 1'b0;
        at_sample();
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== 64'h0 || imem_req !== 1'b0 || pc_stall !== 1'b1 || flush !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drain got pc=%h req=%b stall=%b flush=%b required pc=0 req=0 stall=1 flush=0",
                     pc, imem_req, pc_stall, flush);
        end
        at_drive();
        imem_ready = 1'b1;
        rst = 1'b0;
        at_sample();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_boot got req=%b required 0", imem_req);
        end
        at_drive();
        run_beats(1, 64'h0);
        check_drained("rst_recover");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired required=bench completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wait();
        test_branch();
        test_jump_wait();
        test_priority();
        test_back_to_back();
        test_wrap();
        test_hazard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
